vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Generates VGA-style raster timing from a pixel clock. Each line runs
//   active -> front porch -> sync -> back porch, and each frame follows the
//   same order vertically, so hc==0 / vc==0 is the first visible pixel.
//   All outputs are registered from the counter value held before the clock
//   edge, so every output lags the counters by exactly one enabled clock.
//
// Ports
//   pixel_clock  in   pixel clock, all logic on the rising edge
//   rst          in   asynchronous active-high reset
//   ce           in   pixel clock enable; counters advance only when high
//   Hsync        out  horizontal sync, HSYNC_POL level while asserted
//   Vsync        out  vertical sync, VSYNC_POL level while asserted
//   blank        out  high outside the visible area
//   X            out  visible pixel column (0 while blank)
//   Y            out  visible line (0 while blank)
//   line_start   out  one-cycle pulse at the first pixel of every line
//   frame_start  out  one-cycle pulse at the first pixel of every frame
//   FPSClk       out  one-cycle pulse at the last pixel of the last visible line
//   frame_count  out  completed-frame counter, wraps modulo 2^FC_W
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int X_W       = 10,
  parameter int Y_W       = 9,
  parameter int FC_W      = 8
) (
  input  logic            pixel_clock,
  input  logic            rst,
  input  logic            ce,
  output logic            Hsync,
  output logic            Vsync,
  output logic            blank,
  output logic [X_W-1:0]  X,
  output logic [Y_W-1:0]  Y,
  output logic            line_start,
  output logic            frame_start,
  output logic            FPSClk,
  output logic [FC_W-1:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HC_W    = $clog2(H_TOTAL);
  localparam int VC_W    = $clog2(V_TOTAL);

  // Every boundary is strictly below the total, so all fit the counter width.
  localparam logic [HC_W-1:0] H_LAST     = HC_W'(H_TOTAL - 1);
  localparam logic [HC_W-1:0] H_VIS_END  = HC_W'(H_ACTIVE);
  localparam logic [HC_W-1:0] H_SYNC_BEG = HC_W'(H_ACTIVE + H_FP);
  localparam logic [HC_W-1:0] H_SYNC_END = HC_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VC_W-1:0] V_LAST     = VC_W'(V_TOTAL - 1);
  localparam logic [VC_W-1:0] V_VIS_END  = VC_W'(V_ACTIVE);
  localparam logic [VC_W-1:0] V_VIS_LAST = VC_W'(V_ACTIVE - 1);
  localparam logic [VC_W-1:0] V_SYNC_BEG = VC_W'(V_ACTIVE + V_FP);
  localparam logic [VC_W-1:0] V_SYNC_END = VC_W'(V_ACTIVE + V_FP + V_SYNC);

  // Reject degenerate timings and visible areas that X/Y cannot address.
  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_timing
    $error("vga_timing_gen: timing parameters must all be non-zero");
  end
  if (longint'(H_ACTIVE) > (longint'(1) << X_W) ||
      longint'(V_ACTIVE) > (longint'(1) << Y_W)) begin : g_bad_width
    $error("vga_timing_gen: X_W/Y_W too narrow for the visible area");
  end

  logic [HC_W-1:0] hc, hc_next;
  logic [VC_W-1:0] vc, vc_next;
  logic [FC_W-1:0] fc, fc_next;

  // Raster position advance: hc wraps into vc, vc wraps into the frame count.
  always_comb begin
    hc_next = hc;
    vc_next = vc;
    fc_next = fc;
    if (hc == H_LAST) begin
      hc_next = '0;
      if (vc == V_LAST) begin
        vc_next = '0;
        fc_next = fc + FC_W'(1);
      end else begin
        vc_next = vc + VC_W'(1);
      end
    end else begin
      hc_next = hc + HC_W'(1);
    end
  end

  always_ff @(posedge pixel_clock or posedge rst) begin
    if (rst) begin
      hc <= '0;
      vc <= '0;
      fc <= '0;
    end else if (ce) begin
      hc <= hc_next;
      vc <= vc_next;
      fc <= fc_next;
    end
  end

  logic h_visible, v_visible, visible, hsync_on, vsync_on;
  logic at_line_start, at_frame_start, at_fps_tick;

  // Decode of the current position; registered below to form the outputs.
  always_comb begin
    h_visible      = (hc < H_VIS_END);
    v_visible      = (vc < V_VIS_END);
    visible        = h_visible && v_visible;
    hsync_on       = (hc >= H_SYNC_BEG) && (hc < H_SYNC_END);
    vsync_on       = (vc >= V_SYNC_BEG) && (vc < V_SYNC_END);
    at_line_start  = (hc == '0);
    at_frame_start = (hc == '0) && (vc == '0);
    at_fps_tick    = (hc == H_LAST) && (vc == V_VIS_LAST);
  end

  // frame_count is taken from fc, which has already wrapped by the time the
  // decoder sees (0,0), so the new count appears together with frame_start.
  // Pulses are cleared on disabled cycles so each lasts one enabled clock.
  always_ff @(posedge pixel_clock or posedge rst) begin
    if (rst) begin
      Hsync       <= ~HSYNC_POL;
      Vsync       <= ~VSYNC_POL;
      blank       <= 1'b1;
      X           <= '0;
      Y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      FPSClk      <= 1'b0;
      frame_count <= '0;
    end else if (ce) begin
      Hsync       <= hsync_on ? HSYNC_POL : ~HSYNC_POL;
      Vsync       <= vsync_on ? VSYNC_POL : ~VSYNC_POL;
      blank       <= ~visible;
      X           <= visible ? X_W'(hc) : '0;
      Y           <= visible ? Y_W'(vc) : '0;
      line_start  <= at_line_start;
      frame_start <= at_frame_start;
      FPSClk      <= at_fps_tick;
      frame_count <= fc;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      FPSClk      <= 1'b0;
    end
  end

endmodule
